// File: rtl/vrf_read_sequencer.sv
// vrf_read_sequencer: drives one per-lane VRF address counter for a single vector read stream,
// tracking in-flight BRAM reads so valid/last/index line up with the returned data.
module vrf_read_sequencer #(
  parameter int  MEM_DEPTH         = 512,
  parameter int  VREG_LOC_PER_LANE = 8,
  parameter int  VLANE_NUM         = 8,
  parameter int  READ_LATENCY      = 2,
  localparam int AW                = $clog2(MEM_DEPTH),
  localparam int VL_W              = $clog2(VLANE_NUM * VREG_LOC_PER_LANE * 4) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [VL_W-1:0]   vl_i,
  input  logic [1:0]        element_width_i,
  input  logic              up_down_i,
  input  logic [8*AW-1:0]   start_addr_i,
  input  logic [AW-1:0]     slide_offset_i,
  input  logic              stall_i,
  output logic              ready_o,
  output logic              cnt_load_o,
  output logic              cnt_rst_o,
  output logic              cnt_en_o,
  output logic              cnt_up_down_o,
  output logic [1:0]        cnt_width_o,
  output logic [8*AW-1:0]   cnt_start_addr_o,
  output logic [AW-1:0]     cnt_slide_offset_o,
  output logic              valid_o,
  output logic              last_o,
  output logic [VL_W-2:0]   elem_idx_o,
  output logic              done_o,
  output logic              cfg_err_o
);
  localparam int LG = $clog2(VLANE_NUM);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;
  state_t                  state_q, state_d;
  logic [VL_W-1:0]         remaining_q, remaining_d;
  logic [VL_W-2:0]         idx_q, idx_d;
  logic                    cfg_err_q, cfg_err_d;
  logic                    up_down_q, up_down_d;
  logic [1:0]              width_q, width_d;
  logic [8*AW-1:0]         start_addr_q, start_addr_d;
  logic [AW-1:0]           slide_q, slide_d;
  logic [READ_LATENCY-1:0] pv_q, pv_d, pl_q, pl_d;
  logic [VL_W-2:0]         pi_q [READ_LATENCY];
  logic [VL_W-2:0]         pi_d [READ_LATENCY];
  logic [VL_W:0]           n_raw, lim, n_cnt;
  logic                    bad_ew, over, accept;
  assign ready_o            = state_q == IDLE;
  assign cfg_err_o          = cfg_err_q;
  assign cnt_up_down_o      = up_down_q;
  assign cnt_width_o        = width_q;
  assign cnt_start_addr_o   = start_addr_q;
  assign cnt_slide_offset_o = slide_q;
  assign valid_o            = pv_q[READ_LATENCY-1];
  assign last_o             = valid_o & pl_q[READ_LATENCY-1];
  assign elem_idx_o         = valid_o ? pi_q[READ_LATENCY-1] : '0;
  // Per-lane element count, rounded up, limited by the register group size for this width
  always_comb begin
    n_raw  = ({1'b0, vl_i} + (VL_W+1)'(VLANE_NUM - 1)) >> LG;
    lim    = (VL_W+1)'(VREG_LOC_PER_LANE) << (2'd2 - element_width_i);
    bad_ew = &element_width_i;
    over   = !bad_ew && (n_raw > lim);
    n_cnt  = over ? lim : n_raw;
    accept = start_i && !abort_i && (state_q == IDLE);
  end
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    idx_d        = idx_q;
    cfg_err_d    = cfg_err_q;
    up_down_d    = up_down_q;
    width_d      = width_q;
    start_addr_d = start_addr_q;
    slide_d      = slide_q;
    cnt_load_o   = 1'b0;
    cnt_rst_o    = 1'b0;
    cnt_en_o     = 1'b0;
    done_o       = 1'b0;
    if (abort_i && state_q != IDLE) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          up_down_d    = up_down_i;
          width_d      = element_width_i;
          start_addr_d = start_addr_i;
          slide_d      = slide_offset_i;
          cfg_err_d    = bad_ew || over;
          remaining_d  = n_cnt[VL_W-1:0];
          idx_d        = '0;
          state_d      = (bad_ew || vl_i == '0) ? DONE : LOAD;
        end
        LOAD: begin
          cnt_load_o = 1'b1;
          cnt_rst_o  = 1'b1;
          idx_d      = '0;
          state_d    = RUN;
        end
        RUN: begin
          cnt_en_o = !stall_i;
          if (!stall_i) begin
            idx_d       = idx_q + (VL_W-1)'(1);
            remaining_d = remaining_q - VL_W'(1);
            state_d     = (remaining_q == VL_W'(1)) ? DRAIN : RUN;
          end
        end
        DRAIN: state_d = last_o ? DONE : DRAIN;
        DONE: begin
          done_o  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // Read-latency shadow: advances every cycle so it stays aligned with BRAM data, not with stall
  always_comb begin
    pv_d[0] = cnt_en_o;
    pl_d[0] = remaining_q == VL_W'(1);
    pi_d[0] = idx_q;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pv_d[i] = pv_q[i-1];
      pl_d[i] = pl_q[i-1];
      pi_d[i] = pi_q[i-1];
    end
    if (abort_i) begin
      pv_d = '0;
      pl_d = '0;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      idx_q        <= '0;
      cfg_err_q    <= 1'b0;
      up_down_q    <= 1'b0;
      width_q      <= '0;
      start_addr_q <= '0;
      slide_q      <= '0;
      pv_q         <= '0;
      pl_q         <= '0;
      pi_q         <= '{default: '0};
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      idx_q        <= idx_d;
      cfg_err_q    <= cfg_err_d;
      up_down_q    <= up_down_d;
      width_q      <= width_d;
      start_addr_q <= start_addr_d;
      slide_q      <= slide_d;
      pv_q         <= pv_d;
      pl_q         <= pl_d;
      pi_q         <= pi_d;
    end
  end
endmodule

// File: tb/tb_vrf_read_sequencer.sv
// tb_vrf_read_sequencer: randomized bench; expected activity comes from a per-operation
// schedule (issue cycles, latency-shifted valids, done time) derived from the element count.
module tb_vrf_read_sequencer;
  localparam int AW    = 9;
  localparam int VL_W  = 9;
  localparam int RL    = 2;
  localparam int LANES = 8;
  localparam int VLOC  = 8;
  logic clk_i = 1'b0;
  logic rst_i, start_i, abort_i, up_down_i, stall_i;
  logic [VL_W-1:0] vl_i;
  logic [1:0] element_width_i;
  logic [8*AW-1:0] start_addr_i;
  logic [AW-1:0] slide_offset_i;
  logic ready_o, cnt_load_o, cnt_rst_o, cnt_en_o, cnt_up_down_o;
  logic valid_o, last_o, done_o, cfg_err_o;
  logic [1:0] cnt_width_o;
  logic [8*AW-1:0] cnt_start_addr_o;
  logic [AW-1:0] cnt_slide_offset_o;
  logic [VL_W-2:0] elem_idx_o;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk_i = ~clk_i;
  vrf_read_sequencer dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .vl_i(vl_i), .element_width_i(element_width_i), .up_down_i(up_down_i),
    .start_addr_i(start_addr_i), .slide_offset_i(slide_offset_i), .stall_i(stall_i),
    .ready_o(ready_o), .cnt_load_o(cnt_load_o), .cnt_rst_o(cnt_rst_o), .cnt_en_o(cnt_en_o),
    .cnt_up_down_o(cnt_up_down_o), .cnt_width_o(cnt_width_o),
    .cnt_start_addr_o(cnt_start_addr_o), .cnt_slide_offset_o(cnt_slide_offset_o),
    .valid_o(valid_o), .last_o(last_o), .elem_idx_o(elem_idx_o), .done_o(done_o),
    .cfg_err_o(cfg_err_o)
  );
  function automatic logic [99:0] snap();
    return {ready_o, cnt_load_o, cnt_rst_o, cnt_en_o, valid_o, last_o, done_o, cfg_err_o,
            cnt_up_down_o, cnt_width_o, cnt_start_addr_o, cnt_slide_offset_o, elem_idx_o};
  endfunction
  task automatic run_op(input string name, input int vl, input int ew, input int stall_pct,
                        input int force_stall, output int en_cnt, output int done_cyc);
    bit stl [256];
    bit iss [256];
    int idx_of [256];
    int n, lim, d, issued, p;
    bit err, shortcut;
    logic [95:0] r;
    logic [6:0] exp_v, obs_v;
    r = {$urandom, $urandom, $urandom};
    n = (vl + LANES - 1) / LANES;
    lim = (ew == 3) ? 0 : (VLOC << (2 - ew));
    err = (ew == 3) || (n > lim);
    if (ew != 3 && n > lim) n = lim;
    shortcut = (ew == 3) || (vl == 0);
    for (int c = 0; c < 256; c++) begin
      stl[c] = (c == force_stall) || ((c < 200) && ($urandom_range(99) < stall_pct));
      iss[c] = 1'b0;
      idx_of[c] = 0;
    end
    d = 1;
    if (!shortcut) begin
      issued = 0;
      for (int c = 2; issued < n && c < 250; c++)
        if (!stl[c]) begin
          iss[c] = 1'b1;
          idx_of[c] = issued;
          issued++;
          d = c + RL + 1;
        end
    end
    @(posedge clk_i); #1;
    start_i = 1'b1;
    vl_i = VL_W'(vl);
    element_width_i = 2'(ew);
    up_down_i = r[95];
    start_addr_i = r[71:0];
    slide_offset_i = r[80:72];
    stall_i = 1'b0;
    @(negedge clk_i);
    n_tests++;
    if (ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s idle_ready: got %b want 1", name, ready_o);
    end
    en_cnt = 0;
    done_cyc = -1;
    for (int c = 1; c <= d + 1; c++) begin
      @(posedge clk_i); #1;
      start_i = (c == d);
      stall_i = stl[c];
      @(negedge clk_i);
      p = (c >= RL) ? c - RL : 255;
      exp_v = {c > d, !shortcut && c == 1, !shortcut && c == 1, iss[c], iss[p],
               iss[p] && idx_of[p] == n - 1, c == d};
      obs_v = {ready_o, cnt_load_o, cnt_rst_o, cnt_en_o, valid_o, last_o, done_o};
      n_tests++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL %s cyc%0d rdy/ld/rst/en/vld/last/done: got %b want %b", name, c, obs_v, exp_v);
      end
      if (iss[p]) begin
        n_tests++;
        if (elem_idx_o !== 8'(idx_of[p])) begin
          n_fail++;
          $display("FAIL %s cyc%0d elem_idx: got %0d want %0d", name, c, elem_idx_o, idx_of[p]);
        end
      end
      if (c == 1) begin
        n_tests++;
        if ({cfg_err_o, cnt_up_down_o, cnt_width_o, cnt_start_addr_o, cnt_slide_offset_o} !==
            {err, r[95], 2'(ew), r[71:0], r[80:72]}) begin
          n_fail++;
          $display("FAIL %s config: got err=%b ud=%b w=%0d sa=%h so=%h want err=%b ud=%b w=%0d sa=%h so=%h",
                   name, cfg_err_o, cnt_up_down_o, cnt_width_o, cnt_start_addr_o, cnt_slide_offset_o,
                   err, r[95], ew, r[71:0], r[80:72]);
        end
      end
      if (cnt_en_o) en_cnt++;
      if (done_o && done_cyc < 0) done_cyc = c;
    end
    start_i = 1'b0;
    stall_i = 1'b0;
  endtask
  task automatic test_reset;
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; stall_i = 1'b0; up_down_i = 1'b0;
    vl_i = '0; element_width_i = '0; start_addr_i = '0; slide_offset_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    n_tests++;
    if (snap() !== {1'b1, 99'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got %h want %h", snap(), {1'b1, 99'b0});
    end
    rst_i = 1'b0;
  endtask
  task automatic test_basic;
    int en, dc;
    run_op("word16", 16, 2, 0, -1, en, dc);
    n_tests++;
    if (en != 2 || dc != 6) begin
      n_fail++;
      $display("FAIL word16 summary: got en=%0d done@%0d want en=2 done@6", en, dc);
    end
  endtask
  task automatic test_stall;
    int en, dc;
    run_op("byte20_stall", 20, 0, 0, 3, en, dc);
    n_tests++;
    if (en != 3 || dc != 8) begin
      n_fail++;
      $display("FAIL byte20_stall summary: got en=%0d done@%0d want en=3 done@8", en, dc);
    end
  endtask
  task automatic test_zero_vl;
    int en, dc;
    run_op("vl0", 0, $urandom_range(2), 0, -1, en, dc);
    n_tests++;
    if (en != 0 || dc != 1 || cfg_err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL vl0 summary: got en=%0d done@%0d err=%b want en=0 done@1 err=0", en, dc, cfg_err_o);
    end
  endtask
  task automatic test_clamp;
    int en, dc;
    run_op("word72_clamp", 72, 2, 20, -1, en, dc);
    n_tests++;
    if (en != 8 || dc < 0 || cfg_err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL word72_clamp summary: got en=%0d done@%0d err=%b want en=8 done err=1", en, dc, cfg_err_o);
    end
  endtask
  task automatic test_illegal_ew;
    int en, dc;
    run_op("ew11", 40, 3, 0, -1, en, dc);
    n_tests++;
    if (en != 0 || dc != 1 || cfg_err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL ew11 summary: got en=%0d done@%0d err=%b want en=0 done@1 err=1", en, dc, cfg_err_o);
    end
    run_op("after_err", 8, 0, 0, -1, en, dc);
    n_tests++;
    if (cfg_err_o !== 1'b0 || en != 1) begin
      n_fail++;
      $display("FAIL after_err summary: got err=%b en=%0d want err=0 en=1", cfg_err_o, en);
    end
  endtask
  task automatic test_abort;
    @(posedge clk_i); #1;
    start_i = 1'b1; vl_i = 9'd64; element_width_i = 2'd2; stall_i = 1'b0; abort_i = 1'b0;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 abort_i = 1'b1;
    @(negedge clk_i);
    n_tests++;
    if ({cnt_en_o, done_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_cycle en/done: got %b want 00", {cnt_en_o, done_o});
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk_i); #1;
      abort_i = 1'b0;
      @(negedge clk_i);
      n_tests++;
      if ({ready_o, valid_o, done_o, cnt_en_o, cnt_load_o} !== 5'b10000) begin
        n_fail++;
        $display("FAIL after_abort%0d rdy/vld/done/en/ld: got %b want 10000", k,
                 {ready_o, valid_o, done_o, cnt_en_o, cnt_load_o});
      end
    end
  endtask
  task automatic test_rst_mid;
    @(posedge clk_i); #1;
    start_i = 1'b1; vl_i = 9'd16; element_width_i = 2'd2; up_down_i = 1'b1;
    start_addr_i = {8{9'h1a5}}; slide_offset_i = 9'h33;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b1;
    #1;
    n_tests++;
    if (snap() !== {1'b1, 99'b0}) begin
      n_fail++;
      $display("FAIL rst_in_drain: got %h want %h", snap(), {1'b1, 99'b0});
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      n_tests++;
      if ({ready_o, valid_o, done_o} !== 3'b100) begin
        n_fail++;
        $display("FAIL after_rst%0d rdy/vld/done: got %b want 100", k, {ready_o, valid_o, done_o});
      end
    end
  endtask
  task automatic test_back_to_back;
    int en, dc, ew, vl;
    for (int k = 0; k < 25; k++) begin
      ew = ($urandom_range(9) == 0) ? 3 : $urandom_range(2);
      vl = ($urandom_range(9) == 0) ? 0 : $urandom_range(300, 1);
      run_op($sformatf("rand%0d", k), vl, ew, 30, -1, en, dc);
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero_vl();
    test_clamp();
    test_illegal_ew();
    test_abort();
    test_rst_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
